// File: rtl/timer_pkg.sv
// Shared register map, control-field bit positions and FSM state type for the countdown timer.
package timer_pkg;

    localparam logic CTRL_ADDR = 1'b0;
    localparam logic DATA_ADDR = 1'b1;

    // CTRL write fields
    localparam int unsigned START    = 0;
    localparam int unsigned DONE_CLR = 1;
    localparam int unsigned AUTO     = 2;

    // CTRL read fields (AUTO reads back at its write position)
    localparam int unsigned BUSY = 0;
    localparam int unsigned DONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running tick divider: one-cycle tick_o every PRESCALE enabled cycles, synchronously clearable.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 10000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped countdown timer with sticky DONE flag and level interrupt.
// Auto-reload (CTRL bit2) exists only when TIMER_AUTORELOAD_EN is defined.
module timer_periph
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 10000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        addr_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] reload_q, reload_d;
    logic        done_q, done_d;
    logic        auto_q, auto_d;

    logic        ctrl_wr;
    logic        data_wr;
    logic        presc_clr;
    logic        tick;
    logic        unused_data;

    assign ctrl_wr = we_i && (addr_i == CTRL_ADDR);
    assign data_wr = we_i && (addr_i == DATA_ADDR);

`ifdef TIMER_AUTORELOAD_EN
    assign unused_data = ^data_i[31:3];
`else
    assign unused_data = ^data_i[31:2];
`endif

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q == RUN),
        .clr_i   (presc_clr),
        .tick_o  (tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        done_d    = done_q;
        auto_d    = auto_q;
        presc_clr = 1'b0;

        if (data_wr) begin
            reload_d = data_i;
        end

        if (ctrl_wr) begin
`ifdef TIMER_AUTORELOAD_EN
            auto_d = data_i[AUTO];
`endif
            if (data_i[DONE_CLR]) begin
                done_d = 1'b0;
            end
        end

        if (ctrl_wr && data_i[START]) begin
            presc_clr = 1'b1;
            if (reload_q == '0) begin
                state_d = IDLE;
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
                count_d = reload_q;
                done_d  = 1'b0;
            end
        end else begin
            // Expiry set is applied after the W1C above so that a set wins the collision.
            if ((state_q == RUN) && tick) begin
                if (count_q <= 32'd1) begin
                    done_d = 1'b1;
                    if (auto_q && (reload_q != '0)) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            // A pure acknowledge (DONE_CLR=1, START=0) leaves a running timer running.
            if (ctrl_wr && !data_i[DONE_CLR] && (state_q == RUN)) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            auto_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            auto_q   <= auto_d;
        end
    end

    always_comb begin
        if (addr_i == DATA_ADDR) begin
            data_o = count_q;
        end else begin
            data_o = {29'b0, auto_q, done_q, (state_q == RUN)};
        end
    end

    assign irq_o = done_q;

endmodule

// File: tb/tb_timer_periph.sv
// Directed, table-driven bench for timer_periph at PRESCALE=4; expects TIMER_AUTORELOAD_EN to match the RTL build.
module tb_timer_periph;

    localparam int unsigned PRESCALE = 4;

    typedef struct {
        logic        we;
        logic        waddr;
        logic [31:0] wdata;
        int          idle;
        logic [31:0] exp_ctrl;
        logic [31:0] exp_count;
        logic        exp_irq;
    } vec_t;

    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        addr_i  = 1'b0;
    logic        we_i    = 1'b0;
    logic [31:0] data_i  = '0;
    logic [31:0] data_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    timer_periph #(
        .PRESCALE (PRESCALE)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic addVec(input logic we, input logic waddr, input logic [31:0] wdata, input int idle,
                          input logic [31:0] ectrl, input logic [31:0] ecount, input logic eirq);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.idle = idle;
        v.exp_ctrl = ectrl; v.exp_count = ecount; v.exp_irq = eirq;
        vecs.push_back(v);
    endtask

    // Called at a falling edge; the state seen is after (1 + idle) rising edges.
    task automatic applyStimulus(input vec_t v);
        we_i   = v.we;
        addr_i = v.waddr;
        data_i = v.wdata;
        @(negedge clk_i);
        we_i = 1'b0;
        repeat (v.idle) @(negedge clk_i);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        addr_i = 1'b0;
        #1 check($sformatf("vec%0d ctrl", idx), data_o, v.exp_ctrl);
        addr_i = 1'b1;
        #1 check($sformatf("vec%0d count", idx), data_o, v.exp_count);
        check($sformatf("vec%0d irq", idx), {31'b0, irq_o}, {31'b0, v.exp_irq});
    endtask

    initial begin
        // reset state and basic count of 3 ticks
        addVec(0, 0, 0,          0, 32'h0, 0, 0);
        addVec(1, 1, 3,          0, 32'h0, 0, 0);
        addVec(1, 0, 32'h1,      0, 32'h1, 3, 0);
        addVec(0, 0, 0,         10, 32'h1, 1, 0);
        addVec(0, 0, 0,          0, 32'h2, 0, 1);
        // stop after 9 cycles freezes count at 8
        addVec(1, 1, 10,         0, 32'h2, 0, 1);
        addVec(1, 0, 32'h1,      0, 32'h1, 10, 0);
        addVec(0, 0, 0,          7, 32'h1, 8, 0);
        addVec(1, 0, 32'h0,      0, 32'h0, 8, 0);
        addVec(0, 0, 0,          5, 32'h0, 8, 0);
        // zero reload sets DONE without BUSY, then W1C
        addVec(1, 1, 0,          0, 32'h0, 8, 0);
        addVec(1, 0, 32'h1,      0, 32'h2, 0, 1);
        addVec(0, 0, 0,          3, 32'h2, 0, 1);
        addVec(1, 0, 32'h2,      0, 32'h0, 0, 0);
        // DONE_CLR on the expiry edge: set wins
        addVec(1, 1, 2,          0, 32'h0, 0, 0);
        addVec(1, 0, 32'h1,      0, 32'h1, 2, 0);
        addVec(0, 0, 0,          6, 32'h1, 1, 0);
        addVec(1, 0, 32'h2,      0, 32'h2, 0, 1);
        // reload change mid-run, then restart with the new reload
        addVec(1, 1, 5,          0, 32'h2, 0, 1);
        addVec(1, 0, 32'h1,      0, 32'h1, 5, 0);
        addVec(0, 0, 0,          4, 32'h1, 4, 0);
        addVec(1, 1, 100,        0, 32'h1, 4, 0);
        addVec(0, 0, 0,         12, 32'h1, 1, 0);
        addVec(0, 0, 0,          0, 32'h2, 0, 1);
        addVec(1, 0, 32'h1,      0, 32'h1, 100, 0);
        addVec(0, 0, 0,        398, 32'h1, 1, 0);
        addVec(0, 0, 0,          0, 32'h2, 0, 1);
`ifdef TIMER_AUTORELOAD_EN
        addVec(1, 1, 2,          0, 32'h2, 0, 1);
        addVec(1, 0, 32'h5,      0, 32'h5, 2, 0);
        addVec(0, 0, 0,          6, 32'h5, 1, 0);
        addVec(0, 0, 0,          0, 32'h7, 2, 1);
        addVec(1, 0, 32'h6,      0, 32'h5, 2, 0);
        addVec(0, 0, 0,          5, 32'h5, 1, 0);
        addVec(0, 0, 0,          0, 32'h7, 2, 1);
        addVec(1, 0, 32'h0,      0, 32'h2, 2, 1);
`else
        addVec(1, 1, 2,          0, 32'h2, 0, 1);
        addVec(1, 0, 32'h5,      0, 32'h1, 2, 0);
        addVec(1, 0, 32'h0,      0, 32'h0, 2, 0);
`endif

        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // asynchronous reset in the middle of a count
        @(negedge clk_i);
        we_i = 1'b1; addr_i = 1'b1; data_i = 32'd10;
        @(negedge clk_i);
        addr_i = 1'b0; data_i = 32'h1;
        @(negedge clk_i);
        we_i = 1'b0;
        repeat (5) @(negedge clk_i);
        addr_i = 1'b1;
        #1 check("pre-reset count", data_o, 32'd9);
        #2 rst_n_i = 1'b0;
        #1 check("async reset count", data_o, 32'd0);
        check("async reset irq", {31'b0, irq_o}, 32'd0);
        addr_i = 1'b0;
        #1 check("async reset ctrl", data_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1 check("post-reset ctrl", data_o, 32'd0);
        addr_i = 1'b1;
        #1 check("post-reset count", data_o, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
